// File: rtl/johnson_decoder_monitor.sv
// johnson_decoder_monitor
//   Receive-side monitor for an N-flop Johnson counter bus. It samples code_in
//   on every clock, decodes it to a binary index, classifies each step as
//   hold, forward, reverse or skip, locks onto a clean same-direction run, and
//   keeps a wrapping position count and a saturating lock-loss count.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   UNLOCKED  | no usable reference; waiting for a legal code
//   LOCKING   | counting consecutive same-direction single steps
//   LOCKED    | clean sequence; position tracks steps, a break pulses err
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   code_in    Johnson code under observation (N bits)
//   index      decoded index of the last legal sample (IW bits)
//   valid      last sample was a legal code
//   step_fwd   one-cycle pulse, index advanced by +1 mod 2N
//   step_rev   one-cycle pulse, index moved by -1 mod 2N
//   locked     FSM is in LOCKED
//   err        one-cycle pulse on a lock loss
//   position   wrapping up/down position count (POS_W bits)
//   err_count  saturating count of lock losses (ERR_W bits)

module johnson_decoder_monitor #(
    parameter int N          = 4,
    parameter int LOCK_COUNT = 3,
    parameter int POS_W      = 8,
    parameter int ERR_W      = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N-1:0]             code_in,
    output logic [$clog2(2*N)-1:0]   index,
    output logic                     valid,
    output logic                     step_fwd,
    output logic                     step_rev,
    output logic                     locked,
    output logic                     err,
    output logic [POS_W-1:0]         position,
    output logic [ERR_W-1:0]         err_count
);

    localparam int IW = $clog2(2*N);
    localparam logic [IW:0] TWO_N = (IW+1)'(2*N);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        run_q, run_d, run_nxt;
    logic              dir_set_q, dir_set_d;
    logic              dir_q, dir_d;          // 1 = forward
    logic [IW-1:0]     index_q;
    logic              valid_q;
    logic              step_fwd_q, step_rev_q, err_q;
    logic [POS_W-1:0]  position_q;
    logic [ERR_W-1:0]  err_count_q;

    logic              dec_valid;
    logic [IW-1:0]     dec_idx;
    logic [IW:0]       diff_raw, diff;
    logic              both_legal, is_hold, is_fwd, is_rev, is_skip;
    logic              lock_loss;

    // Code for index k: the first N codes fill ones in from the MSB, the
    // remaining ones clear from the MSB (matches the down-counter sequence).
    function automatic logic [N-1:0] jcode(input int k);
        logic [N-1:0] c;
        c = '0;
        for (int j = 0; j < N; j++) begin
            if (k <= N) c[N-1-j] = (j < k);
            else        c[N-1-j] = (j >= k - N);
        end
        return c;
    endfunction

    always_comb begin
        dec_valid = 1'b0;
        dec_idx   = '0;
        for (int k = 0; k < 2*N; k++) begin
            if (code_in == jcode(k)) begin
                dec_valid = 1'b1;
                dec_idx   = IW'(k);
            end
        end
    end

    // Modular difference computed with one extra bit so non-power-of-two 2N
    // still wraps correctly. valid_q doubles as the previous-sample-legal flag.
    always_comb begin
        diff_raw   = {1'b0, dec_idx} + TWO_N - {1'b0, index_q};
        diff       = (diff_raw >= TWO_N) ? (diff_raw - TWO_N) : diff_raw;
        both_legal = dec_valid && valid_q;
        is_hold    = both_legal && (diff == '0);
        is_fwd     = both_legal && (diff == (IW+1)'(1));
        is_rev     = both_legal && !is_fwd && (diff == TWO_N - (IW+1)'(1));
        is_skip    = both_legal && !is_hold && !is_fwd && !is_rev;
    end

    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        dir_set_d = dir_set_q;
        dir_d     = dir_q;
        run_nxt   = run_q;
        lock_loss = 1'b0;
        case (state_q)
            ST_UNLOCKED: begin
                if (dec_valid) begin
                    state_d   = ST_LOCKING;
                    run_d     = '0;
                    dir_set_d = 1'b0;
                    dir_d     = 1'b0;
                end
            end
            ST_LOCKING: begin
                if (!dec_valid || is_skip) begin
                    state_d   = ST_UNLOCKED;
                    run_d     = '0;
                    dir_set_d = 1'b0;
                end else if (is_fwd || is_rev) begin
                    if (!dir_set_q || (dir_q == is_fwd)) run_nxt = run_q + 4'd1;
                    else                                 run_nxt = 4'd1;
                    run_d     = run_nxt;
                    dir_set_d = 1'b1;
                    dir_d     = is_fwd;
                    if (run_nxt >= 4'(LOCK_COUNT)) state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!dec_valid || is_skip) begin
                    state_d   = ST_UNLOCKED;
                    run_d     = '0;
                    dir_set_d = 1'b0;
                    lock_loss = 1'b1;
                end
            end
            default: begin
                state_d = ST_UNLOCKED;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_UNLOCKED;
            run_q       <= '0;
            dir_set_q   <= 1'b0;
            dir_q       <= 1'b0;
            index_q     <= '0;
            valid_q     <= 1'b0;
            step_fwd_q  <= 1'b0;
            step_rev_q  <= 1'b0;
            err_q       <= 1'b0;
            position_q  <= '0;
            err_count_q <= '0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            dir_set_q  <= dir_set_d;
            dir_q      <= dir_d;
            valid_q    <= dec_valid;
            if (dec_valid) index_q <= dec_idx;
            step_fwd_q <= is_fwd;
            step_rev_q <= is_rev;
            err_q      <= lock_loss;
            // Only steps taken while already locked move the position.
            if (state_q == ST_LOCKED) begin
                if (is_fwd)      position_q <= position_q + 1'b1;
                else if (is_rev) position_q <= position_q - 1'b1;
            end
            if (lock_loss && (err_count_q != '1)) err_count_q <= err_count_q + 1'b1;
        end
    end

    assign index     = index_q;
    assign valid     = valid_q;
    assign step_fwd  = step_fwd_q;
    assign step_rev  = step_rev_q;
    assign locked    = (state_q == ST_LOCKED);
    assign err       = err_q;
    assign position  = position_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_johnson_decoder_monitor.sv
module tb_johnson_decoder_monitor;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] code_in;
    logic [2:0] index;
    logic       valid, step_fwd, step_rev, locked, err;
    logic [7:0] position;
    logic [3:0] err_count;

    johnson_decoder_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .code_in   (code_in),
        .index     (index),
        .valid     (valid),
        .step_fwd  (step_fwd),
        .step_rev  (step_rev),
        .locked    (locked),
        .err       (err),
        .position  (position),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] idx;
        logic       v, f, r, l, e;
        logic [7:0] pos;
        logic [3:0] ec;
    } out_t;

    typedef struct packed {
        logic       rst;
        logic [3:0] code;
        out_t       exp;
    } vec_t;

    vec_t tbl[$];
    out_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic rst, input logic [3:0] code,
                                input logic [2:0] idx, input logic v, input logic f,
                                input logic r, input logic l, input logic e,
                                input logic [7:0] pos, input logic [3:0] ec);
        vec_t x;
        x.rst  = rst;
        x.code = code;
        x.exp  = '{idx: idx, v: v, f: f, r: r, l: l, e: e, pos: pos, ec: ec};
        return x;
    endfunction

    function automatic void t(input logic [3:0] code, input logic [2:0] idx,
                              input logic v, input logic f, input logic r,
                              input logic l, input logic e, input logic [7:0] pos,
                              input logic [3:0] ec);
        tbl.push_back(mk(1'b0, code, idx, v, f, r, l, e, pos, ec));
    endfunction

    task automatic apply(input vec_t x, input string name);
        out_t got, want;
        @(negedge clk);
        reset   = x.rst;
        code_in = x.code;
        sb.push_back(x.exp);
        @(posedge clk);
        #1;
        got  = '{idx: index, v: valid, f: step_fwd, r: step_rev, l: locked,
                 e: err, pos: position, ec: err_count};
        want = sb.pop_front();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got idx=%0d v=%b f=%b r=%b l=%b e=%b pos=%0d ec=%0d, expected idx=%0d v=%b f=%b r=%b l=%b e=%b pos=%0d ec=%0d",
                     name, got.idx, got.v, got.f, got.r, got.l, got.e, got.pos, got.ec,
                     want.idx, want.v, want.f, want.r, want.l, want.e, want.pos, want.ec);
        end
    endtask

    task automatic do_reset(input string name);
        apply(mk(1'b1, 4'b0000, 3'd0, 0, 0, 0, 0, 0, 8'd0, 4'd0), name);
    endtask

    initial begin
        reset   = 1'b1;
        code_in = 4'b0000;

        do_reset("reset_a");
        do_reset("reset_b");

        // forward lock
        t(4'b0000, 0, 1, 0, 0, 0, 0, 8'd0,   0);
        t(4'b1000, 1, 1, 1, 0, 0, 0, 8'd0,   0);
        t(4'b1100, 2, 1, 1, 0, 0, 0, 8'd0,   0);
        t(4'b1110, 3, 1, 1, 0, 1, 0, 8'd0,   0);
        t(4'b1111, 4, 1, 1, 0, 1, 0, 8'd1,   0);
        // reverse back to index 1, through position 0
        t(4'b1110, 3, 1, 0, 1, 1, 0, 8'd0,   0);
        t(4'b1100, 2, 1, 0, 1, 1, 0, 8'd255, 0);
        t(4'b1000, 1, 1, 0, 1, 1, 0, 8'd254, 0);
        // reverse wrap 0 -> 7
        t(4'b1000, 1, 1, 0, 0, 1, 0, 8'd254, 0);
        t(4'b0000, 0, 1, 0, 1, 1, 0, 8'd253, 0);
        t(4'b0001, 7, 1, 0, 1, 1, 0, 8'd252, 0);
        t(4'b0011, 6, 1, 0, 1, 1, 0, 8'd251, 0);
        t(4'b0111, 5, 1, 0, 1, 1, 0, 8'd250, 0);
        t(4'b1111, 4, 1, 0, 1, 1, 0, 8'd249, 0);
        t(4'b1110, 3, 1, 0, 1, 1, 0, 8'd248, 0);
        // hold
        for (int i = 0; i < 10; i++) t(4'b1110, 3, 1, 0, 0, 1, 0, 8'd248, 0);
        // skip while locked
        t(4'b1100, 2, 1, 0, 1, 1, 0, 8'd247, 0);
        t(4'b1111, 4, 1, 0, 0, 0, 1, 8'd247, 1);
        t(4'b1111, 4, 1, 0, 0, 0, 0, 8'd247, 1);
        // relock forward, wrap 7 -> 0 counted as forward
        t(4'b0111, 5, 1, 1, 0, 0, 0, 8'd247, 1);
        t(4'b0011, 6, 1, 1, 0, 0, 0, 8'd247, 1);
        t(4'b0001, 7, 1, 1, 0, 1, 0, 8'd247, 1);
        t(4'b0000, 0, 1, 1, 0, 1, 0, 8'd248, 1);
        // illegal code while locked, then while unlocked
        t(4'b0101, 0, 0, 0, 0, 0, 1, 8'd248, 2);
        t(4'b0101, 0, 0, 0, 0, 0, 0, 8'd248, 2);
        // skip while locking gives no err
        t(4'b0000, 0, 1, 0, 0, 0, 0, 8'd248, 2);
        t(4'b1000, 1, 1, 1, 0, 0, 0, 8'd248, 2);
        t(4'b1110, 3, 1, 0, 0, 0, 0, 8'd248, 2);
        // direction reversal during locking restarts the run at 1
        t(4'b1100, 2, 1, 0, 1, 0, 0, 8'd248, 2);
        t(4'b1000, 1, 1, 0, 1, 0, 0, 8'd248, 2);
        t(4'b1100, 2, 1, 1, 0, 0, 0, 8'd248, 2);
        t(4'b1110, 3, 1, 1, 0, 0, 0, 8'd248, 2);
        t(4'b1111, 4, 1, 1, 0, 1, 0, 8'd248, 2);
        t(4'b1111, 4, 1, 0, 0, 1, 0, 8'd248, 2);

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("vec%0d", i));

        // reset mid-lock with position 5, then full relock needed
        do_reset("reset_c");
        apply(mk(0, 4'b0000, 0, 1, 0, 0, 0, 0, 8'd0, 0), "ml_0");
        apply(mk(0, 4'b1000, 1, 1, 1, 0, 0, 0, 8'd0, 0), "ml_1");
        apply(mk(0, 4'b1100, 2, 1, 1, 0, 0, 0, 8'd0, 0), "ml_2");
        apply(mk(0, 4'b1110, 3, 1, 1, 0, 1, 0, 8'd0, 0), "ml_3");
        apply(mk(0, 4'b1111, 4, 1, 1, 0, 1, 0, 8'd1, 0), "ml_4");
        apply(mk(0, 4'b0111, 5, 1, 1, 0, 1, 0, 8'd2, 0), "ml_5");
        apply(mk(0, 4'b0011, 6, 1, 1, 0, 1, 0, 8'd3, 0), "ml_6");
        apply(mk(0, 4'b0001, 7, 1, 1, 0, 1, 0, 8'd4, 0), "ml_7");
        apply(mk(0, 4'b0000, 0, 1, 1, 0, 1, 0, 8'd5, 0), "ml_8");
        apply(mk(1, 4'b1000, 0, 0, 0, 0, 0, 0, 8'd0, 0), "reset_mid_lock");
        apply(mk(0, 4'b1000, 1, 1, 0, 0, 0, 0, 8'd0, 0), "rl_first");
        apply(mk(0, 4'b1100, 2, 1, 1, 0, 0, 0, 8'd0, 0), "rl_1");
        apply(mk(0, 4'b1110, 3, 1, 1, 0, 0, 0, 8'd0, 0), "rl_2");
        apply(mk(0, 4'b1111, 4, 1, 1, 0, 1, 0, 8'd0, 0), "rl_3");

        // repeated lock/break: err_count saturates at 15
        for (int i = 0; i < 20; i++) begin
            logic [3:0] ec;
            logic [2:0] held;
            ec   = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            held = (i == 0) ? 3'd4 : 3'd3;
            apply(mk(0, 4'b0101, held, 0, 0, 0, 0, 1, 8'd0, ec), $sformatf("sat_brk%0d", i));
            apply(mk(0, 4'b0000, 0, 1, 0, 0, 0, 0, 8'd0, ec), $sformatf("sat_a%0d", i));
            apply(mk(0, 4'b1000, 1, 1, 1, 0, 0, 0, 8'd0, ec), $sformatf("sat_b%0d", i));
            apply(mk(0, 4'b1100, 2, 1, 1, 0, 0, 0, 8'd0, ec), $sformatf("sat_c%0d", i));
            apply(mk(0, 4'b1110, 3, 1, 1, 0, 1, 0, 8'd0, ec), $sformatf("sat_d%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
